// File: rtl/lenet_conv_pkg.sv
// rtl/lenet_conv_pkg.sv - shared constants and FSM state type for the conv channel adder
package lenet_conv_pkg;
    localparam int CH_DATA_W  = 23;
    localparam int CH_ADD_LAT = 3;

    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DRAIN, ST_DONE} chadd_state_t;

    // Index width that stays legal when a dimension has a single entry.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/channel_adder_ctrl_if.sv
// rtl/channel_adder_ctrl_if.sv - beat input and tagged result output streams of channel_adder_ctrl
interface channel_adder_ctrl_if
    import lenet_conv_pkg::*;
#(
    parameter int IMG_W  = 10,
    parameter int IMG_H  = 10,
    parameter int OUT_CH = 16
);
    localparam int MAP_W = idx_w(OUT_CH);
    localparam int ROW_W = idx_w(IMG_H);
    localparam int COL_W = idx_w(IMG_W);

    logic                 in_valid;
    logic                 in_ready;
    logic [CH_DATA_W-1:0] d1, d2, d3, d4, d5, d6;
    logic                 out_valid;
    logic                 out_ready;
    logic [CH_DATA_W-1:0] out_data;
    logic [MAP_W-1:0]     out_map;
    logic [ROW_W-1:0]     out_row;
    logic [COL_W-1:0]     out_col;

    modport master (
        output in_valid, d1, d2, d3, d4, d5, d6, out_ready,
        input  in_ready, out_valid, out_data, out_map, out_row, out_col
    );
    modport slave (
        input  in_valid, d1, d2, d3, d4, d5, d6, out_ready,
        output in_ready, out_valid, out_data, out_map, out_row, out_col
    );
endinterface

// File: rtl/chadd_result_fifo.sv
// rtl/chadd_result_fifo.sv - synchronous result FIFO with count/full/empty, zero data while empty
module chadd_result_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic             do_push, do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end
endmodule

// File: rtl/channel_adder.sv
// rtl/channel_adder.sv - three-stage stall-free six-input 23-bit wrapping adder tree
module channel_adder
    import lenet_conv_pkg::*;
(
    input  logic                 clk,
    input  logic [CH_DATA_W-1:0] d1,
    input  logic [CH_DATA_W-1:0] d2,
    input  logic [CH_DATA_W-1:0] d3,
    input  logic [CH_DATA_W-1:0] d4,
    input  logic [CH_DATA_W-1:0] d5,
    input  logic [CH_DATA_W-1:0] d6,
    output logic [CH_DATA_W-1:0] sum
);
    logic [CH_DATA_W-1:0] s12, s34, s56, s1234, s56_d;

    always_ff @(posedge clk) begin
        s12   <= d1 + d2;
        s34   <= d3 + d4;
        s56   <= d5 + d6;
        s1234 <= s12 + s34;
        s56_d <= s56;
        sum   <= s1234 + s56_d;
    end
endmodule

// File: rtl/channel_adder_ctrl.sv
// rtl/channel_adder_ctrl.sv - pass sequencer and credit flow control around channel_adder; optional ReLU via CHADD_RELU_EN
module channel_adder_ctrl
    import lenet_conv_pkg::*;
#(
    parameter int IMG_W      = 10,
    parameter int IMG_H      = 10,
    parameter int OUT_CH     = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    output logic busy,
    output logic done,
    channel_adder_ctrl_if.slave bus
);
    localparam int MAP_W = idx_w(OUT_CH);
    localparam int ROW_W = idx_w(IMG_H);
    localparam int COL_W = idx_w(IMG_W);
    localparam int TAG_W = MAP_W + ROW_W + COL_W;
    localparam int ENT_W = CH_DATA_W + TAG_W;
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam int OCC_W = CNT_W + 2;

    chadd_state_t          state, state_nxt;
    logic [MAP_W-1:0]      map_q;
    logic [ROW_W-1:0]      row_q;
    logic [COL_W-1:0]      col_q;
    logic [CH_ADD_LAT-1:0] vld_pipe;
    logic [TAG_W-1:0]      tag_pipe [CH_ADD_LAT];
    logic [CH_DATA_W-1:0]  sum, res;
    logic [ENT_W-1:0]      fifo_rdata;
    logic [CNT_W-1:0]      fifo_count;
    logic                  fifo_full, fifo_empty;
    logic [OCC_W-1:0]      occ;
    logic                  accept, pop, push, last_beat;

    // Credits cover beats still in the adder, so the FIFO can always absorb them.
    assign pop          = !fifo_empty && bus.out_ready;
    assign push         = vld_pipe[CH_ADD_LAT-1];
    assign occ          = OCC_W'($countones(vld_pipe)) + OCC_W'(fifo_count) - OCC_W'(pop);
    assign bus.in_ready = (state == ST_RUN) && (occ < OCC_W'(FIFO_DEPTH));
    assign accept       = bus.in_valid && bus.in_ready;
    assign last_beat    = (map_q == MAP_W'(OUT_CH - 1)) && (row_q == ROW_W'(IMG_H - 1)) &&
                          (col_q == COL_W'(IMG_W - 1));

    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        busy      = (state != ST_IDLE);
        done      = 1'b0;
        case (state)
            ST_IDLE:  if (start) state_nxt = ST_RUN;
            ST_RUN:   if (accept && last_beat) state_nxt = ST_DRAIN;
            ST_DRAIN: if (vld_pipe == '0 && fifo_empty) state_nxt = ST_DONE;
            ST_DONE: begin
                done      = 1'b1;
                state_nxt = ST_IDLE;
            end
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst || (state == ST_IDLE && start)) begin
            map_q <= '0;
            row_q <= '0;
            col_q <= '0;
        end else if (accept) begin
            if (col_q == COL_W'(IMG_W - 1)) begin
                col_q <= '0;
                if (row_q == ROW_W'(IMG_H - 1)) begin
                    row_q <= '0;
                    map_q <= (map_q == MAP_W'(OUT_CH - 1)) ? '0 : map_q + MAP_W'(1);
                end else begin
                    row_q <= row_q + ROW_W'(1);
                end
            end else begin
                col_q <= col_q + COL_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) vld_pipe <= '0;
        else     vld_pipe <= {vld_pipe[CH_ADD_LAT-2:0], accept};
    end

    // Tags ride alongside the adder every cycle; the valid pipe says which are real.
    always_ff @(posedge clk) begin
        tag_pipe[0] <= {map_q, row_q, col_q};
        for (int i = 1; i < CH_ADD_LAT; i++) tag_pipe[i] <= tag_pipe[i-1];
    end

    channel_adder u_adder (
        .clk (clk),
        .d1  (bus.d1),
        .d2  (bus.d2),
        .d3  (bus.d3),
        .d4  (bus.d4),
        .d5  (bus.d5),
        .d6  (bus.d6),
        .sum (sum)
    );

`ifdef CHADD_RELU_EN
    assign res = sum[CH_DATA_W-1] ? '0 : sum;
`else
    assign res = sum;
`endif

    chadd_result_fifo #(.WIDTH(ENT_W), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .wdata ({res, tag_pipe[CH_ADD_LAT-1]}),
        .pop   (pop),
        .rdata (fifo_rdata),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign bus.out_valid = !fifo_empty;
    assign {bus.out_data, bus.out_map, bus.out_row, bus.out_col} = fifo_rdata;

    always_ff @(posedge clk) begin
        if (!rst) assert (!(push && fifo_full && !pop));
    end
endmodule

// File: tb/tb_channel_adder_ctrl.sv
// tb/tb_channel_adder_ctrl.sv - randomized scoreboard bench for channel_adder_ctrl (honours CHADD_RELU_EN)
module tb_channel_adder_ctrl;
    import lenet_conv_pkg::*;

    localparam int IMG_W      = 10;
    localparam int IMG_H      = 10;
    localparam int OUT_CH     = 16;
    localparam int FIFO_DEPTH = 4;
    localparam int TOTAL      = IMG_W * IMG_H * OUT_CH;
    localparam int MW         = $clog2(OUT_CH);
    localparam int RW         = $clog2(IMG_H);
    localparam int CW         = $clog2(IMG_W);
    localparam int EW         = CH_DATA_W + MW + RW + CW;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    logic busy, done;

    channel_adder_ctrl_if #(.IMG_W(IMG_W), .IMG_H(IMG_H), .OUT_CH(OUT_CH)) bus ();

    channel_adder_ctrl #(
        .IMG_W(IMG_W), .IMG_H(IMG_H), .OUT_CH(OUT_CH), .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .busy  (busy),
        .done  (done),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int checks = 0, errors = 0;
    int cyc = 0;
    int beat_idx = 0, out_cnt = 0, done_cnt = 0, out_at_done = -1;
    int first_acc = -1, first_out = -1;
    bit pending = 1'b0, prev_done = 1'b0;
    logic [137:0]   cur_beat = '0;
    logic [137:0]   dir_q [$];
    logic [EW-1:0]  exp_q [$];
    logic [EW-1:0]  mon_act;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void check(input string name, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, expv);
        end
    endfunction

    function automatic logic [137:0] pack6(input logic [22:0] a, b, c, d, e, f);
        return {f, e, d, c, b, a};
    endfunction

    // Reference: signed sum of six channels modulo 2^23, tag from beat ordinal.
    function automatic logic [EW-1:0] model(input int k, input logic [137:0] v);
        int s;
        logic [CH_DATA_W-1:0] r;
        s = 0;
        for (int i = 0; i < 6; i++) s += int'($signed(v[i*23 +: 23]));
        r = s[CH_DATA_W-1:0];
`ifdef CHADD_RELU_EN
        if (r[CH_DATA_W-1]) r = '0;
`endif
        return {r, MW'(k / (IMG_H * IMG_W)), RW'((k / IMG_W) % IMG_H), CW'(k % IMG_W)};
    endfunction

    task automatic load_directed();
        dir_q.push_back(pack6(23'h7FFF9C, 23'd10, 23'd10, 23'd10, 23'd10, 23'd10));
        dir_q.push_back(pack6(23'h3FFFFF, 23'd1, 23'd0, 23'd0, 23'd0, 23'd0));
        dir_q.push_back(pack6(23'd1, 23'd2, 23'd3, 23'd4, 23'd5, 23'd6));
        dir_q.push_back(pack6(23'h7FFFFF, 23'h7FFFFF, 23'h7FFFFF, 23'h7FFFFF, 23'h7FFFFF, 23'h7FFFFF));
        dir_q.push_back(pack6(23'h400000, 23'h400000, 23'h400000, 23'h400000, 23'h400000, 23'h400000));
    endtask

    task automatic step(input int in_pct, input int out_pct, input bit do_start);
        @(posedge clk);
        #1;
        start = do_start;
        if (!pending && int'($urandom_range(0, 99)) < in_pct) begin
            if (dir_q.size() > 0) cur_beat = dir_q.pop_front();
            else for (int i = 0; i < 6; i++) cur_beat[i*23 +: 23] = 23'($urandom);
            pending = 1'b1;
        end
        bus.in_valid  = pending;
        bus.d1 = cur_beat[0 +: 23];
        bus.d2 = cur_beat[23 +: 23];
        bus.d3 = cur_beat[46 +: 23];
        bus.d4 = cur_beat[69 +: 23];
        bus.d5 = cur_beat[92 +: 23];
        bus.d6 = cur_beat[115 +: 23];
        bus.out_ready = (int'($urandom_range(0, 99)) < out_pct);
        @(negedge clk);
        if (bus.in_valid && bus.in_ready === 1'b1) begin
            if (first_acc < 0) first_acc = cyc;
            exp_q.push_back(model(beat_idx, cur_beat));
            beat_idx++;
            pending = 1'b0;
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (bus.out_valid === 1'b1 && first_out < 0) first_out = cyc;
            if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
                out_cnt++;
                mon_act = {bus.out_data, bus.out_map, bus.out_row, bus.out_col};
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL sb_unexpected: got %0h with no expected entry", mon_act);
                end else begin
                    check("sb_out", 64'(mon_act), 64'(exp_q.pop_front()));
                end
            end
            if (done === 1'b1) begin
                done_cnt++;
                out_at_done = out_cnt;
                check("busy_during_done", 64'(busy), 64'd1);
            end
            if (prev_done && done !== 1'b1) check("busy_after_done", 64'(busy), 64'd0);
        end
        prev_done = (done === 1'b1);
    end

    task automatic run_pass(input string name, input int in_pct, input int out_pct,
                            input int hold_off, input bit sustained, input bit poke_start);
        int guard, drops, b;
        guard = 0;
        drops = 0;
        beat_idx = 0; out_cnt = 0; done_cnt = 0; out_at_done = -1;
        first_acc = -1; first_out = -1;
        step(in_pct, (hold_off > 0) ? 0 : out_pct, 1'b1);
        step(in_pct, (hold_off > 0) ? 0 : out_pct, 1'b0);
        check({name, "_in_ready_after_start"}, 64'(bus.in_ready), 64'd1);
        check({name, "_busy_after_start"}, 64'(busy), 64'd1);
        while (done_cnt == 0 && guard < 20000) begin
            b = beat_idx;
            step(in_pct, (guard < hold_off) ? 0 : out_pct, poke_start && guard == 40);
            if (sustained && b < TOTAL && bus.in_ready !== 1'b1) drops++;
            if (hold_off > 0 && guard == hold_off - 1) begin
                check({name, "_accepts_backpressured"}, 64'(beat_idx), 64'(FIFO_DEPTH));
                check({name, "_in_ready_backpressured"}, 64'(bus.in_ready), 64'd0);
            end
            guard++;
        end
        bus.in_valid = 1'b0;
        pending = 1'b0;
        repeat (3) step(0, 100, 1'b0);
        check({name, "_done_pulses"}, 64'(done_cnt), 64'd1);
        check({name, "_accepted"}, 64'(beat_idx), 64'(TOTAL));
        check({name, "_outputs"}, 64'(out_cnt), 64'(TOTAL));
        check({name, "_outputs_before_done"}, 64'(out_at_done), 64'(TOTAL));
        check({name, "_scoreboard_empty"}, 64'(exp_q.size()), 64'd0);
        check({name, "_busy_idle"}, 64'(busy), 64'd0);
        check({name, "_first_out_latency"}, 64'(first_out - first_acc), 64'd4);
        if (sustained) check({name, "_in_ready_drops"}, 64'(drops), 64'd0);
    endtask

    initial begin
        int guard;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b0;
        bus.d1 = '0; bus.d2 = '0; bus.d3 = '0; bus.d4 = '0; bus.d5 = '0; bus.d6 = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", 64'(bus.in_ready), 64'd0);
        check("rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_out_data", 64'(bus.out_data), 64'd0);
        check("rst_out_tag", 64'({bus.out_map, bus.out_row, bus.out_col}), 64'd0);
        rst = 1'b0;

        load_directed();
        repeat (5) begin
            step(100, 100, 1'b0);
            check("idle_in_ready", 64'(bus.in_ready), 64'd0);
        end
        check("idle_accepts", 64'(beat_idx), 64'd0);

        run_pass("sustained", 100, 100, 0, 1'b1, 1'b1);

        load_directed();
        run_pass("backpressure", 100, 50, 20, 1'b0, 1'b0);

        beat_idx = 0;
        step(100, 100, 1'b1);
        guard = 0;
        while (beat_idx < 3 && guard < 50) begin
            step(100, 100, 1'b0);
            guard++;
        end
        check("rst_run_accepts", 64'(beat_idx), 64'd3);
        @(posedge clk);
        #1;
        rst = 1'b1;
        bus.in_valid = 1'b0;
        pending = 1'b0;
        exp_q.delete();
        @(posedge clk);
        #1;
        check("midrst_out_valid", 64'(bus.out_valid), 64'd0);
        check("midrst_busy", 64'(busy), 64'd0);
        check("midrst_in_ready", 64'(bus.in_ready), 64'd0);
        rst = 1'b0;
        out_cnt = 0;
        repeat (8) step(0, 100, 1'b0);
        check("midrst_no_stale", 64'(out_cnt), 64'd0);

        load_directed();
        run_pass("random", 60, 60, 0, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, checks %0d errors %0d", checks, errors);
        $fatal(1);
    end
endmodule

// File: doc/channel_adder_ctrl.md
# channel_adder_ctrl

Sequencer and flow-control wrapper around the three-stage, stall-free `channel_adder` pipeline in the convolution layer. It accepts one six-channel partial-sum beat per pixel from the per-channel conv units, tags each beat with its map/row/col position, and tracks beats in flight through the fixed-latency adder. Results land in a credit-protected result FIFO so that downstream back-pressure never loses data. It frames one layer pass (OUT_CH maps of IMG_H×IMG_W pixels) between `start` and `done`.

## Interface
- IMG_W, default 10: pixels per row.
- IMG_H, default 10: rows per map.
- OUT_CH, default 16: output maps per pass.
- FIFO_DEPTH, default 4: result FIFO entries; power of two, ≥4.
- clk  in  1: the single clock.
- rst  in  1: reset, synchronous and active-high.
- start  in  1: pulse that begins a pass; honoured only in IDLE.
- in_valid  in  1: d1..d6 hold a valid beat.
- in_ready  out  1: the beat is accepted when in_valid && in_ready.
- d1..d6  in  23 each: two's-complement channel partial sums.
- out_valid  out  1: FIFO head is valid.
- out_ready  in  1: the downstream block pops the head.
- out_data  out  23: channel sum, optional ReLU applied.
- out_map  out  $clog2(OUT_CH): map index of the head.
- out_row  out  $clog2(IMG_H): row index of the head.
- out_col  out  $clog2(IMG_W): column index of the head.
- busy  out  1: high in any state other than IDLE.
- done  out  1: one-cycle pulse at the end of a pass.

## Operation
- The FSM has four states: IDLE, RUN, DRAIN, DONE.
  - IDLE→RUN on start. On entry the map, row and col counters clear.
  - RUN→DRAIN when the last beat (map OUT_CH-1, row IMG_H-1, col IMG_W-1) is accepted.
  - DRAIN→DONE when no beat is in flight and the FIFO is empty.
  - DONE→IDLE unconditionally.
- The counters advance on each accepted beat.
  - col wraps IMG_W-1→0 and carries to row.
  - row wraps IMG_H-1→0 and carries to map.
- d1..d6 pass straight to the adder every cycle. The adder has no enable and no reset.
- A 3-bit valid shift register and a 3-deep tag shift register (map, row, col) run in parallel with the adder.
  - A beat shifts a 1 into the valid register only when it is accepted.
  - When the valid register's tail bit is 1, {result, tag} is pushed into the FIFO.
- Credit rule:
  - occ = popcount(valid pipe) + fifo_count − (out_valid && out_ready).
  - in_ready = (state==RUN) && (occ < FIFO_DEPTH).
  - This rule guarantees the FIFO never overflows, so the push needs no full check.
- Arithmetic: 23-bit two's complement. Overflow wraps and is not saturated, which matches the adder.
- Boundary conditions:
  - Push and pop in the same cycle leave fifo_count unchanged.
  - A push into an empty FIFO makes the entry visible on out_valid the next cycle; there is no bypass.
  - start while busy is ignored.
  - in_valid outside RUN is ignored.
  - rst in any state clears the FSM, counters, valid pipe and FIFO pointers on the next edge. Values still inside the adder are discarded because their valid bits are cleared.

## Timing
- Reset values: in_ready=0, out_valid=0, busy=0, done=0. out_data, out_map, out_row and out_col are 0.
- start at edge t gives busy=1 and in_ready=1 from t+1.
- A beat accepted at edge t reaches the adder output at t+3, is pushed at t+3, and shows out_valid=1 from t+4.
- Throughput: one beat per cycle sustained while out_ready=1, for FIFO_DEPTH≥4.
- With out_ready=0, at most FIFO_DEPTH beats are accepted. in_ready then stays low until pops resume.
- done pulses exactly one cycle after the DRAIN exit condition is met. busy falls in the same cycle that done falls.

## Configuration
- CHADD_RELU_EN defined: out_data = result[22] ? 23'd0 : result. The ReLU is applied at the FIFO write.
- CHADD_RELU_EN undefined: out_data is the raw signed sum.
- Latency and handshake are identical in both cases.

## Structure
- Shared package lenet_conv_pkg holds:
  - CH_DATA_W = 23.
  - CH_ADD_LAT = 3.
  - The FSM state enum chadd_state_t.
- Sub-module chadd_result_fifo:
  - Synchronous FIFO, parameterised width and depth.
  - Provides count, full and empty.
  - Reset is synchronous and active-high.
- The controller instantiates `channel_adder` and chadd_result_fifo once each.

## Test plan
- IMG_W=IMG_H=2, OUT_CH=1, d1..d6=1..6 every beat, out_ready=1: four outputs of 21, tags (0,0,0),(0,0,1),(0,1,0),(0,1,1). First out_valid arrives 4 cycles after the first accept, and done follows the last pop.
- Continuous in_valid, out_ready=1, default parameters: in_ready never drops in RUN, 1600 outputs, one done pulse.
- out_ready=0 from start: exactly FIFO_DEPTH accepts, then in_ready=0. Restoring out_ready gives in-order data with no loss or duplication.
- d1=−100 (two's complement), d2..d6=10: output is 23'h7FFFCE (−50) without CHADD_RELU_EN and 0 with it. d1=23'h3FFFFF with d2=1 wraps to 23'h400000.
- rst asserted mid-RUN with three beats in flight: the next cycle shows out_valid=0, busy=0 and no stale pushes. A fresh start then runs a clean pass from tag (0,0,0).
- start pulsed during RUN and in_valid during IDLE: both are ignored, and counters and output count are unaffected.
